aes_round_seq: RTL
==================

Name: aes_round_seq

Overview:
- Parametrised round-sequencing controller for the AES datapath. Supersedes the fixed 10-round, decrypt-only controller.
- Supports AES-128/192/256 (Nr = 10/12/14), selected per operation.
- Supports the forward cipher and the inverse cipher in one block.
- Provides a start/busy/done handshake, a key-expansion ready handshake and synchronous abort.
- Drives the per-step enable strobes and the round-key index to the datapath and key-schedule RAM.

Parameters:
- CNT_W, 4: width of the round and round-key-index outputs; must hold NR_256.
- NR_128, 10: round count for key_len = 2'b00.
- NR_192, 12: round count for key_len = 2'b01.
- NR_256, 14: round count for key_len = 2'b10.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- decrypt  input  1  0 = forward cipher, 1 = inverse cipher; latched with start.
- key_len  input  2  key size select; 2'b11 is illegal; latched with start.
- key_ready  input  1  key schedule is valid; sampled only in KEY.
- abort  input  1  synchronous cancel of the current operation.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final AddRoundKey.
- err  output  1  one-cycle pulse when start arrives with an illegal key_len.
- round  output  CNT_W  current round number, 0..Nr.
- rk_idx  output  CNT_W  round-key index: round when encrypting, Nr - round when decrypting.
- add_round_en  output  1  AddRoundKey strobe.
- sub_en  output  1  (Inv)SubBytes strobe.
- shift_en  output  1  (Inv)ShiftRows strobe.
- mix_en  output  1  (Inv)MixColumns strobe.
- first_round  output  1  high during the round-0 AddRoundKey; datapath muxes the input block instead of the state register.

Behaviour:
- Reset: state = IDLE; all outputs 0; round = 0; latched mode and Nr cleared. Reset mid-operation aborts immediately with no done.
- States: IDLE, KEY, ARK, SUB, SHIFT, MIX, DONE. Registered state; strobes are Moore outputs of the current state and are high for exactly that one cycle.
- IDLE:
  - start with legal key_len: latch decrypt and Nr, set round = 0, go to KEY.
  - start with key_len = 2'b11: pulse err next cycle, stay in IDLE.
- KEY: wait until key_ready = 1, then go to ARK. Occupies at least one cycle.
- Forward order:
  - ARK(r0) -> SUB -> SHIFT -> MIX -> ARK, repeated for rounds 1..Nr-1.
  - Final round: SUB -> SHIFT -> ARK(Nr), with no MIX.
- Inverse order:
  - ARK(r0, rk_idx = Nr) -> SHIFT -> SUB -> ARK -> MIX, repeated for rounds 1..Nr-1.
  - Final round: SHIFT -> SUB -> ARK(rk_idx = 0).
- round increments on the clock edge that leaves each ARK, except after the final ARK.
- After the final ARK (round = Nr): go to DONE. DONE asserts done for one cycle, then returns to IDLE.
- round holds Nr in DONE and in IDLE until the next start.
- Latency: from the first ARK to the final ARK inclusive is exactly 4*Nr cycles (40/48/56).
- start while busy is ignored; no queuing.
- key_len and decrypt changes while busy have no effect.
- abort:
  - In any busy state, abort forces IDLE on the next edge; no done, strobes low from that cycle.
  - Abort in DONE: done still pulses, then IDLE.
  - Abort and start in the same IDLE cycle: start wins.
- key_ready deasserting after KEY is ignored.
- first_round = (state == ARK) && (round == 0).

Test Plan:
- AES-128 encrypt, key_ready tied 1, start at edge T -> KEY at T+1; ARK with first_round=1 at T+2; final ARK at T+41 with round=10, rk_idx=10; done at T+42 only; busy low at T+43; strobe order matches the forward sequence; mix_en count = 9.
- AES-256 decrypt -> 56 cycles ARK-to-ARK; rk_idx sequence over the ARK cycles is 14,13,...,0; mix_en count = 13; the ARK immediately after each MIX appears in the SHIFT-SUB-ARK-MIX order.
- AES-192 encrypt with key_ready raised 5 cycles after entering KEY -> KEY held 5 cycles; then 48-cycle sequence; round ends at 12.
- start with key_len=2'b11 -> err single pulse; busy stays 0; no strobes. Then a legal start -> normal operation.
- abort asserted during round 5 SUB -> IDLE next cycle; done never asserts; a new start then runs a full, clean sequence.
- reset driven low mid-MIX -> all outputs 0 asynchronously. start pulsed while busy -> ignored; the sequence length is unchanged.

Source files
------------

// File: rtl/aes_round_seq_if.sv
// Host-side bundle for the AES round sequencer: operation request,
// key-schedule handshake, status and the per-step datapath strobes.
interface aes_round_seq_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             decrypt;
    logic [1:0]       key_len;
    logic             key_ready;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] round;
    logic [CNT_W-1:0] rk_idx;
    logic             add_round_en;
    logic             sub_en;
    logic             shift_en;
    logic             mix_en;
    logic             first_round;

    // Sequencer side
    modport slave (
        input  start, decrypt, key_len, key_ready, abort,
        output busy, done, err, round, rk_idx,
               add_round_en, sub_en, shift_en, mix_en, first_round
    );

    // Host / datapath side
    modport master (
        output start, decrypt, key_len, key_ready, abort,
        input  busy, done, err, round, rk_idx,
               add_round_en, sub_en, shift_en, mix_en, first_round
    );
endinterface

// File: rtl/aes_round_seq.sv
// AES round-sequencing controller: walks the forward or inverse round
// order for AES-128/192/256 and drives one datapath strobe per cycle
// together with the round number and the round-key index.
module aes_round_seq #(
    parameter int CNT_W  = 4,
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic           clk,
    input  logic           reset,
    aes_round_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        ARK,
        SUB,
        SHIFT,
        MIX,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] NR128_C = CNT_W'(NR_128);
    localparam logic [CNT_W-1:0] NR192_C = CNT_W'(NR_192);
    localparam logic [CNT_W-1:0] NR256_C = CNT_W'(NR_256);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic             dec_q, dec_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] nr_sel;
    logic             key_len_ok;
    logic             last_round;

    assign key_len_ok = (bus.key_len != 2'b11);
    assign last_round = (round_q == nr_q);

    // Round count for the requested key size.
    always_comb begin
        nr_sel = '0;
        case (bus.key_len)
            2'b00:   nr_sel = NR128_C;
            2'b01:   nr_sel = NR192_C;
            2'b10:   nr_sel = NR256_C;
            default: nr_sel = '0;
        endcase
    end

    // Next-state, round counter and latched-mode update.
    // round advances when leaving every non-final ARK, so in the inverse
    // order the MIX that follows an ARK already reports the next round.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (key_len_ok) begin
                        state_d = KEY;
                        round_d = '0;
                        nr_d    = nr_sel;
                        dec_d   = bus.decrypt;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            KEY: begin
                if (bus.abort)
                    state_d = IDLE;
                else if (bus.key_ready)
                    state_d = ARK;
            end
            ARK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (last_round) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + ONE_C;
                    if (!dec_q)
                        state_d = SUB;
                    else if (round_q == '0)
                        state_d = SHIFT;
                    else
                        state_d = MIX;
                end
            end
            SUB: begin
                if (bus.abort)
                    state_d = IDLE;
                else
                    state_d = dec_q ? ARK : SHIFT;
            end
            SHIFT: begin
                if (bus.abort)
                    state_d = IDLE;
                else if (dec_q)
                    state_d = SUB;
                else
                    state_d = last_round ? ARK : MIX;
            end
            MIX: begin
                if (bus.abort)
                    state_d = IDLE;
                else
                    state_d = dec_q ? SHIFT : ARK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath-control registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= '0;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.err          = err_q;
    assign bus.round        = round_q;
    assign bus.rk_idx       = dec_q ? (nr_q - round_q) : round_q;
    assign bus.add_round_en = (state_q == ARK);
    assign bus.sub_en       = (state_q == SUB);
    assign bus.shift_en     = (state_q == SHIFT);
    assign bus.mix_en       = (state_q == MIX);
    assign bus.first_round  = (state_q == ARK) && (round_q == '0);

endmodule
